fcmp_lanes: RTL and testbench

- Parametrised, pipelined successor of the scalar/paired FP compare unit. Compares LANES independent IEEE-format lanes of A and B.
- Produces per-lane all-ones/all-zeros masks for vector compares and the 6-bit scalar flag word for lane 0.
- Holds a sticky invalid-operation status bit.
- Sits in the FP/SIMD execution cluster after operand bypass; its result feeds writeback and the flag rename path.

---
 rtl/fcmp_lanes_if.sv | 32 +++
 rtl/fcmp_lanes.sv | 199 +++++++++++++++++++
 tb/tb_fcmp_lanes.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fcmp_lanes_if.sv
// Operand/result bundle for the lane-parallel FP compare unit.
// The master drives operands and control; the compare unit is the slave.
interface fcmp_lanes_if #(
    parameter int EXP_W = 11,
    parameter int MAN_W = 52,
    parameter int LANES = 2
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic                 in_en;
    logic [LANES*W-1:0]   A;
    logic [LANES*W-1:0]   B;
    logic [2:0]           cmod;
    logic                 ord;
    logic [LANES-1:0]     lane_en;
    logic                 exc_clr;
    logic                 out_en;
    logic [LANES*W-1:0]   res;
    logic [5:0]           flags;
    logic                 exc_inv;
    logic                 exc_now;

    modport master (
        output in_en, A, B, cmod, ord, lane_en, exc_clr,
        input  out_en, res, flags, exc_inv, exc_now
    );

    modport slave (
        input  in_en, A, B, cmod, ord, lane_en, exc_clr,
        output out_en, res, flags, exc_inv, exc_now
    );
endinterface

// File: rtl/fcmp_lanes.sv
// Pipelined multi-lane IEEE floating-point compare.
// Produces per-lane all-ones/all-zeros predicate masks, the lane-0 flag word
// {~C, U, 0, S, Z, U}, a per-op invalid indication and a sticky invalid bit.
// Stage 1 captures operand classification and exponent/fraction compares;
// the final stage captures predicate masks, flags and the invalid indication.
// With PIPE=1 the classification stage is bypassed combinationally.
module fcmp_lanes #(
    parameter int EXP_W = 11,
    parameter int MAN_W = 52,
    parameter int LANES = 2,
    parameter int PIPE  = 2
) (
    input logic         clk,
    input logic         rst,
    fcmp_lanes_if.slave bus
);
    localparam int W = 1 + EXP_W + MAN_W;

    typedef struct packed {
        logic a_nan;
        logic b_nan;
        logic snan;
        logic both_zero;
        logic sgn_a;
        logic sgn_b;
        logic exp_lt;
        logic exp_eq;
        logic frac_lt;
        logic frac_eq;
    } cls_t;

    // Classify one lane's operand pair and compare exponent/fraction fields
    // separately; magnitude order is rebuilt from these carries downstream.
    function automatic cls_t classify(input logic [W-1:0] a, input logic [W-1:0] b);
        cls_t             c;
        logic [EXP_W-1:0] ea;
        logic [EXP_W-1:0] eb;
        logic [MAN_W-1:0] fa;
        logic [MAN_W-1:0] fb;
        ea          = a[W-2 -: EXP_W];
        eb          = b[W-2 -: EXP_W];
        fa          = a[MAN_W-1:0];
        fb          = b[MAN_W-1:0];
        c.a_nan     = (&ea) & (|fa);
        c.b_nan     = (&eb) & (|fb);
        c.snan      = (c.a_nan & ~fa[MAN_W-1]) | (c.b_nan & ~fb[MAN_W-1]);
        c.both_zero = ~(|a[W-2:0]) & ~(|b[W-2:0]);
        c.sgn_a     = a[W-1];
        c.sgn_b     = b[W-1];
        c.exp_lt    = (ea < eb);
        c.exp_eq    = (ea == eb);
        c.frac_lt   = (fa < fb);
        c.frac_eq   = (fa == fb);
        return c;
    endfunction

    // Ordering relation {U, Z, S} in sign-magnitude order; +0 and -0 tie.
    function automatic logic [2:0] order_uzs(input cls_t c);
        logic u;
        logic z;
        logic s;
        logic mag_eq;
        logic mag_lt;
        u      = c.a_nan | c.b_nan;
        mag_eq = c.exp_eq & c.frac_eq;
        mag_lt = c.exp_lt | (c.exp_eq & c.frac_lt);
        z      = ~u & (((c.sgn_a == c.sgn_b) & mag_eq) | c.both_zero);
        s      = ~u & ~c.both_zero &
                 ((c.sgn_a & ~c.sgn_b) |
                  (~c.sgn_a & ~c.sgn_b & mag_lt) |
                  (c.sgn_a & c.sgn_b & ~mag_lt & ~mag_eq));
        return {u, z, s};
    endfunction

    // Select the requested predicate from the ordering relation.
    function automatic logic eval_pred(input logic [2:0] cm, input logic [2:0] uzs);
        logic p;
        logic u;
        logic z;
        logic s;
        {u, z, s} = uzs;
        p = 1'b0;
        case (cm)
            3'd0:    p = z;
            3'd1:    p = ~z;
            3'd2:    p = s;
            3'd3:    p = s | z;
            3'd4:    p = ~u & ~s & ~z;
            3'd5:    p = ~u & ~s;
            3'd6:    p = u;
            default: p = ~u;
        endcase
        return p;
    endfunction

    cls_t [LANES-1:0] cls_c;

    // Per-lane classification of the incoming operands.
    always_comb begin
        cls_c = '0;
        for (int i = 0; i < LANES; i++) begin
            cls_c[i] = classify(bus.A[i*W +: W], bus.B[i*W +: W]);
        end
    end

    cls_t [LANES-1:0] cls_s2;
    logic [LANES-1:0] lane_en_s2;
    logic [2:0]       cmod_s2;
    logic             ord_s2;
    logic             vld_s2;

    generate
        if (PIPE == 2) begin : g_p1
            cls_t [LANES-1:0] cls_p1;
            logic [LANES-1:0] lane_en_p1;
            logic [2:0]       cmod_p1;
            logic             ord_p1;
            logic             vld_p1;

            // ---- stage 1: valid bit (control, reset) ----
            always_ff @(posedge clk or posedge rst) begin
                if (rst) vld_p1 <= 1'b0;
                else     vld_p1 <= bus.in_en;
            end

            // Stage 1 data: classification, compare carries and op control.
            always_ff @(posedge clk) begin
                cls_p1     <= cls_c;
                lane_en_p1 <= bus.lane_en;
                cmod_p1    <= bus.cmod;
                ord_p1     <= bus.ord;
            end

            assign cls_s2     = cls_p1;
            assign lane_en_s2 = lane_en_p1;
            assign cmod_s2    = cmod_p1;
            assign ord_s2     = ord_p1;
            assign vld_s2     = vld_p1;
        end else begin : g_bypass
            assign cls_s2     = cls_c;
            assign lane_en_s2 = bus.lane_en;
            assign cmod_s2    = bus.cmod;
            assign ord_s2     = bus.ord;
            assign vld_s2     = bus.in_en;
        end
    endgenerate

    logic [LANES*W-1:0] res_c;
    logic               inv_c;
    logic [2:0]         uzs0_c;
    logic [5:0]         flags_c;

    // Predicate masks and invalid detection; disabled lanes stay silent.
    always_comb begin
        res_c = '0;
        inv_c = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            res_c[i*W +: W] = {W{lane_en_s2[i] & eval_pred(cmod_s2, order_uzs(cls_s2[i]))}};
            inv_c = inv_c | (lane_en_s2[i] &
                    (cls_s2[i].snan | (ord_s2 & (cls_s2[i].a_nan | cls_s2[i].b_nan))));
        end
    end

    // Lane-0 flag word {~C, U, 0, S, Z, U}, with C = U | S.
    assign uzs0_c  = order_uzs(cls_s2[0]);
    assign flags_c = {~(uzs0_c[2] | uzs0_c[0]), uzs0_c[2], 1'b0, uzs0_c[0], uzs0_c[1], uzs0_c[2]};

    logic               vld_p2;
    logic [LANES*W-1:0] res_p2;
    logic [5:0]         flags_p2;
    logic               exc_p2;
    logic               exc_inv_q;

    // ---- stage 2: result valid bit (control, reset) ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_p2 <= 1'b0;
        else     vld_p2 <= vld_s2;
    end

    // Result data: masks, flags and per-op invalid.
    always_ff @(posedge clk) begin
        res_p2   <= res_c;
        flags_p2 <= flags_c;
        exc_p2   <= inv_c;
    end

    // Sticky invalid: a new set on out_en wins over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) exc_inv_q <= 1'b0;
        else     exc_inv_q <= (exc_inv_q & ~bus.exc_clr) | (vld_p2 & exc_p2);
    end

    // Data registers are not reset, so every result output is gated by valid.
    assign bus.out_en  = vld_p2;
    assign bus.res     = vld_p2 ? res_p2 : '0;
    assign bus.flags   = vld_p2 ? flags_p2 : 6'd0;
    assign bus.exc_now = vld_p2 & exc_p2;
    assign bus.exc_inv = exc_inv_q;
endmodule

// File: tb/tb_fcmp_lanes.sv
// Bench for fcmp_lanes: a single-precision two-lane PIPE=2 instance and a
// double-precision one-lane PIPE=1 instance, checked against a reference
// model that orders operands through signed integer keys.
module tb_fcmp_lanes;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fcmp_lanes_if #(.EXP_W(8),  .MAN_W(23), .LANES(2)) sp_if ();
    fcmp_lanes_if #(.EXP_W(11), .MAN_W(52), .LANES(1)) dp_if ();

    fcmp_lanes #(.EXP_W(8), .MAN_W(23), .LANES(2), .PIPE(2)) u_sp (
        .clk (clk),
        .rst (rst),
        .bus (sp_if)
    );

    fcmp_lanes #(.EXP_W(11), .MAN_W(52), .LANES(1), .PIPE(1)) u_dp (
        .clk (clk),
        .rst (rst),
        .bus (dp_if)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          v;
        logic [63:0] res;
        logic [5:0]  fl;
        bit          exc;
    } exp_t;

    exp_t pipe_q [2];
    bit   sticky;

    function automatic exp_t empty_exp();
        exp_t e;
        e.v = 1'b0; e.res = 64'd0; e.fl = 6'd0; e.exc = 1'b0;
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: NaNs are unordered; otherwise order by a signed key built
    // from sign and magnitude (both zeros map to key 0).
    function automatic void ref_lane(input logic [63:0] x, input logic [63:0] y,
                                     input int ew, input int mw,
                                     input logic [2:0] cm, input bit od, input bit en,
                                     output bit pred, output bit inv, output logic [5:0] fl);
        logic [63:0] emask, fmask, mmask, ex, ey, fx, fy;
        bit          nx, ny, snx, sny, u, z, s, p;
        longint      kx, ky;
        emask = (64'd1 << ew) - 64'd1;
        fmask = (64'd1 << mw) - 64'd1;
        mmask = (64'd1 << (ew + mw)) - 64'd1;
        ex = (x >> mw) & emask;
        ey = (y >> mw) & emask;
        fx = x & fmask;
        fy = y & fmask;
        nx  = (ex == emask) && (fx != 64'd0);
        ny  = (ey == emask) && (fy != 64'd0);
        snx = nx && (fx[mw-1] == 1'b0);
        sny = ny && (fy[mw-1] == 1'b0);
        kx = x[ew+mw] ? -longint'(x & mmask) : longint'(x & mmask);
        ky = y[ew+mw] ? -longint'(y & mmask) : longint'(y & mmask);
        u = nx || ny;
        z = !u && (kx == ky);
        s = !u && (kx < ky);
        case (cm)
            3'd0: p = z;
            3'd1: p = !z;
            3'd2: p = s;
            3'd3: p = s || z;
            3'd4: p = !u && !s && !z;
            3'd5: p = !u && !s;
            3'd6: p = u;
            default: p = !u;
        endcase
        pred = en && p;
        inv  = en && (snx || sny || (od && u));
        fl   = {~(u | s), u, 1'b0, s, z, u};
    endfunction

    // One single-precision cycle: check what is on the outputs now, then
    // drive this cycle's inputs and advance the expected-result delay line.
    task automatic cycle_sp(input bit en, input logic [31:0] a0, input logic [31:0] a1,
                            input logic [31:0] b0, input logic [31:0] b1,
                            input logic [2:0] cm, input bit od, input logic [1:0] le,
                            input bit clr);
        exp_t       cur, nw;
        bit         p0, p1, i0, i1;
        logic [5:0] f0, f1;
        @(negedge clk);
        cur = pipe_q[1];
        check("sp_out_en",  64'(sp_if.out_en),  64'(cur.v));
        check("sp_res",     sp_if.res,          cur.res);
        check("sp_flags",   64'(sp_if.flags),   64'(cur.fl));
        check("sp_exc_now", 64'(sp_if.exc_now), 64'(cur.exc));
        check("sp_exc_inv", 64'(sp_if.exc_inv), 64'(sticky));
        sticky = (sticky & ~clr) | (cur.v & cur.exc);
        sp_if.in_en   = en;
        sp_if.A       = {a1, a0};
        sp_if.B       = {b1, b0};
        sp_if.cmod    = cm;
        sp_if.ord     = od;
        sp_if.lane_en = le;
        sp_if.exc_clr = clr;
        ref_lane({32'd0, a0}, {32'd0, b0}, 8, 23, cm, od, le[0], p0, i0, f0);
        ref_lane({32'd0, a1}, {32'd0, b1}, 8, 23, cm, od, le[1], p1, i1, f1);
        nw = empty_exp();
        if (en) begin
            nw.v   = 1'b1;
            nw.res = {{32{p1}}, {32{p0}}};
            nw.fl  = f0;
            nw.exc = i0 | i1;
        end
        pipe_q[1] = pipe_q[0];
        pipe_q[0] = nw;
    endtask

    task automatic bubble(input bit clr = 1'b0);
        cycle_sp(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 3'd0, 1'b0, 2'b00, clr);
    endtask

    task automatic reset_mid();
        @(negedge clk);
        rst           = 1'b1;
        sp_if.in_en   = 1'b0;
        sp_if.exc_clr = 1'b0;
        #1;
        check("rst_mid_out_en",  64'(sp_if.out_en),  64'd0);
        check("rst_mid_res",     sp_if.res,          64'd0);
        check("rst_mid_exc_inv", 64'(sp_if.exc_inv), 64'd0);
        pipe_q[0] = empty_exp();
        pipe_q[1] = empty_exp();
        sticky    = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rnd_sp();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'h0000_0000;
            1: v = 32'h8000_0000;
            2: v = {1'($urandom_range(0, 1)), 31'h7F80_0000};
            3: v = {1'($urandom_range(0, 1)), 31'h7FC0_0000} | ($urandom & 32'h003F_FFFF);
            4: v = {1'($urandom_range(0, 1)), 31'h7F80_0000} | 32'($urandom_range(1, 32'h003F_FFFF));
            5: v = $urandom & 32'h807F_FFFF;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // One double-precision op on the PIPE=1 instance.
    task automatic dp_op(input logic [63:0] a, input logic [63:0] b,
                         input logic [2:0] cm, input bit od);
        bit         p, iv;
        logic [5:0] f;
        @(negedge clk);
        check("dp_idle_out_en", 64'(dp_if.out_en), 64'd0);
        dp_if.in_en   = 1'b1;
        dp_if.A       = a;
        dp_if.B       = b;
        dp_if.cmod    = cm;
        dp_if.ord     = od;
        dp_if.lane_en = 1'b1;
        ref_lane(a, b, 11, 52, cm, od, 1'b1, p, iv, f);
        @(negedge clk);
        check("dp_out_en",  64'(dp_if.out_en),  64'd1);
        check("dp_res",     dp_if.res,          {64{p}});
        check("dp_flags",   64'(dp_if.flags),   64'(f));
        check("dp_exc_now", 64'(dp_if.exc_now), 64'(iv));
        dp_if.in_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a0, a1, b0, b1;
        logic [63:0] da, db;

        sp_if.in_en = 1'b0; sp_if.A = '0; sp_if.B = '0; sp_if.cmod = 3'd0;
        sp_if.ord = 1'b0; sp_if.lane_en = 2'b00; sp_if.exc_clr = 1'b0;
        dp_if.in_en = 1'b0; dp_if.A = '0; dp_if.B = '0; dp_if.cmod = 3'd0;
        dp_if.ord = 1'b0; dp_if.lane_en = 1'b0; dp_if.exc_clr = 1'b0;
        pipe_q[0] = empty_exp();
        pipe_q[1] = empty_exp();
        sticky = 1'b0;

        // Reset state
        #2;
        check("reset_out_en",  64'(sp_if.out_en),  64'd0);
        check("reset_res",     sp_if.res,          64'd0);
        check("reset_flags",   64'(sp_if.flags),   64'd0);
        check("reset_exc_inv", 64'(sp_if.exc_inv), 64'd0);
        check("reset_exc_now", 64'(sp_if.exc_now), 64'd0);
        check("reset_dp_out_en", 64'(dp_if.out_en), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // LT: lane0 1.0<2.0 true, lane1 2.0<2.0 false
        cycle_sp(1'b1, 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 3'd2, 1'b0, 2'b11, 1'b0);
        bubble();
        bubble();
        check("tp_lt_res",   sp_if.res,        64'h0000_0000_FFFF_FFFF);
        check("tp_lt_flags", 64'(sp_if.flags), 64'(6'b000100));

        // EQ: -0 vs +0
        cycle_sp(1'b1, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 3'd0, 1'b0, 2'b11, 1'b0);
        bubble();
        bubble();
        check("tp_eq_res",   sp_if.res,        64'hFFFF_FFFF_FFFF_FFFF);
        check("tp_eq_flags", 64'(sp_if.flags), 64'(6'b100010));

        // GE with qNaN, quiet then signalling
        cycle_sp(1'b1, 32'h7FC0_0000, 32'h7FC0_0000, 32'h3F80_0000, 32'h3F80_0000, 3'd5, 1'b0, 2'b11, 1'b0);
        bubble();
        bubble();
        check("tp_qnan_flags",   64'(sp_if.flags),   64'(6'b010001));
        check("tp_qnan_exc_now", 64'(sp_if.exc_now), 64'd0);
        cycle_sp(1'b1, 32'h7FC0_0000, 32'h7FC0_0000, 32'h3F80_0000, 32'h3F80_0000, 3'd5, 1'b1, 2'b11, 1'b0);
        bubble();
        bubble();
        check("tp_ord_exc_now", 64'(sp_if.exc_now), 64'd1);
        bubble();
        check("tp_ord_exc_inv", 64'(sp_if.exc_inv), 64'd1);
        bubble(1'b1);
        bubble();

        // sNaN on a disabled lane, then enabled
        cycle_sp(1'b1, 32'h3F80_0000, 32'h7F80_0001, 32'h3F80_0000, 32'h3F80_0000, 3'd0, 1'b0, 2'b01, 1'b0);
        bubble();
        bubble();
        bubble();
        check("tp_snan_masked_inv", 64'(sp_if.exc_inv), 64'd0);
        cycle_sp(1'b1, 32'h3F80_0000, 32'h7F80_0001, 32'h3F80_0000, 32'h3F80_0000, 3'd0, 1'b0, 2'b11, 1'b0);
        bubble();
        bubble();
        bubble();
        check("tp_snan_inv", 64'(sp_if.exc_inv), 64'd1);

        // Clear coinciding with a new set: set wins; then a lone clear
        cycle_sp(1'b1, 32'h3F80_0000, 32'h7F80_0001, 32'h3F80_0000, 32'h3F80_0000, 3'd1, 1'b0, 2'b11, 1'b0);
        bubble();
        bubble(1'b1);
        bubble();
        check("tp_set_wins_inv", 64'(sp_if.exc_inv), 64'd1);
        bubble(1'b1);
        bubble();
        check("tp_clear_inv", 64'(sp_if.exc_inv), 64'd0);

        // Back-to-back ops with alternating predicates
        cycle_sp(1'b1, 32'h3F80_0000, 32'hC000_0000, 32'h4000_0000, 32'hBF80_0000, 3'd2, 1'b0, 2'b11, 1'b0);
        cycle_sp(1'b1, 32'h3F80_0000, 32'hC000_0000, 32'h4000_0000, 32'hBF80_0000, 3'd4, 1'b0, 2'b11, 1'b0);
        cycle_sp(1'b1, 32'h0000_0001, 32'h8000_0001, 32'h0000_0002, 32'h8000_0000, 3'd2, 1'b0, 2'b11, 1'b0);
        cycle_sp(1'b1, 32'h0000_0001, 32'h8000_0001, 32'h0000_0002, 32'h8000_0000, 3'd4, 1'b0, 2'b11, 1'b0);
        bubble();
        bubble();
        bubble();

        // Reset in flight after the second issue
        cycle_sp(1'b1, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 3'd0, 1'b0, 2'b11, 1'b0);
        cycle_sp(1'b1, 32'h7F80_0001, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 3'd7, 1'b1, 2'b11, 1'b0);
        reset_mid();
        for (int i = 0; i < 4; i++) bubble();

        // Randomised traffic
        for (int i = 0; i < 300; i++) begin
            a0 = rnd_sp();
            a1 = rnd_sp();
            b0 = ($urandom_range(0, 3) == 0) ? a0 : rnd_sp();
            b1 = ($urandom_range(0, 3) == 0) ? a1 : rnd_sp();
            cycle_sp(($urandom_range(0, 3) != 0), a0, a1, b0, b1, 3'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                     ($urandom_range(0, 7) == 0));
        end
        bubble();
        bubble();
        bubble();

        // Double precision, PIPE=1
        dp_op(64'hC000_0000_0000_0000, 64'hBFF0_0000_0000_0000, 3'd2, 1'b0);
        check("tp_dp_lt_res", dp_if.res, 64'hFFFF_FFFF_FFFF_FFFF);
        dp_op(64'hC000_0000_0000_0000, 64'hBFF0_0000_0000_0000, 3'd4, 1'b0);
        check("tp_dp_gt_res", dp_if.res, 64'h0);
        dp_op(64'h7FF0_0000_0000_0001, 64'h3FF0_0000_0000_0000, 3'd6, 1'b0);
        dp_op(64'h8000_0000_0000_0000, 64'h0000_0000_0000_0000, 3'd3, 1'b0);
        for (int i = 0; i < 20; i++) begin
            da = {$urandom, $urandom};
            db = ($urandom_range(0, 3) == 0) ? da : {$urandom, $urandom};
            dp_op(da, db, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end
        @(negedge clk);
        check("dp_final_idle", 64'(dp_if.out_en), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
